vec_sum_pipe: RTL and testbench



---
 rtl/vec_sum_pipe_pkg.sv | 39 +++
 rtl/vec_sum_reduce.sv | 81 ++++++++
 rtl/vec_sum_pipe.sv | 80 ++++++++
 tb/tb_vec_sum_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_sum_pipe_pkg.sv
// Shared sizing helpers and the element-slice macro for the vec_* blocks.
// Stage sizes halve (rounding up) at every pairwise level until one element is left.
`ifndef VEC_SUM_PIPE_PKG_SV
`define VEC_SUM_PIPE_PKG_SV

`define VEC_ELEM(v, i, w) v[(i)*(w) +: (w)]

package vec_sum_pipe_pkg;

    function automatic int float_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int ceil_half(input int n);
        return (n + 1) / 2;
    endfunction

    function automatic int num_levels(input int n);
        int s;
        int l;
        s = n;
        l = 0;
        while (s > 1) begin
            s = ceil_half(s);
            l++;
        end
        return l;
    endfunction

    function automatic int stage_size(input int n, input int k);
        int s;
        s = ceil_half(n);
        for (int i = 0; i < k; i++) s = ceil_half(s);
        return s;
    endfunction

endpackage

`endif

// File: rtl/vec_sum_reduce.sv
// One combinational pairwise-sum level: out[j] = in[2j] + in[2j+1], odd tail passes through.
// Denormal inputs are flushed to zero; results are rounded to nearest even.
module vec_sum_reduce
    import vec_sum_pipe_pkg::*;
#(
    parameter int VEC_SIZE       = 8,
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int BIAS           = 127
) (
    input  logic [VEC_SIZE*float_width(EXP_WIDTH, MANTISSA_WIDTH)-1:0]            vec_i,
    output logic [ceil_half(VEC_SIZE)*float_width(EXP_WIDTH, MANTISSA_WIDTH)-1:0] sum_o
);
    localparam int FW       = float_width(EXP_WIDTH, MANTISSA_WIDTH);
    localparam int EW       = EXP_WIDTH;
    localparam int MW       = MANTISSA_WIDTH;
    localparam int EMAX     = 2 * BIAS + 1;
    localparam int OUT_SIZE = ceil_half(VEC_SIZE);

    function automatic logic [FW-1:0] float_add(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic [FW-1:0] x, y;
        logic [MW+4:0] mx, my, acc;
        logic [MW+1:0] man;
        logic          sticky, inc;
        int            ex, ey, sh;
        // x is always the operand of larger magnitude
        if (a[FW-2:0] >= b[FW-2:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        ex = int'(x[FW-2:MW]);
        ey = int'(y[FW-2:MW]);
        if (ex == EMAX) return x;
        if (ey == 0) return (ex == 0) ? '0 : x;
        mx = {2'b01, x[MW-1:0], 3'b000};
        my = {2'b01, y[MW-1:0], 3'b000};
        sh = ex - ey;
        sticky = 1'b0;
        for (int i = 0; i < MW + 5; i++)
            if (i < sh) sticky = sticky | my[i];
        my = my >> sh;
        my[0] = my[0] | sticky;
        if (x[FW-1] == y[FW-1]) begin
            acc = mx + my;
            if (acc[MW+4]) begin
                acc = {1'b0, acc[MW+4:2], acc[1] | acc[0]};
                ex++;
            end
        end else begin
            acc = mx - my;
            if (acc == '0) return '0;
            for (int i = 0; i < MW + 4; i++)
                if (!acc[MW+3]) begin
                    acc = acc << 1;
                    ex--;
                end
        end
        inc = acc[2] & (acc[1] | acc[0] | acc[3]);
        man = {1'b0, acc[MW+3:3]} + {{(MW+1){1'b0}}, inc};
        if (man[MW+1]) begin
            man = man >> 1;
            ex++;
        end
        if (ex >= EMAX) return {x[FW-1], {EW{1'b1}}, {MW{1'b0}}};
        if (ex <= 0) return {x[FW-1], {(FW-1){1'b0}}};
        return {x[FW-1], ex[EW-1:0], man[MW-1:0]};
    endfunction

    for (genvar j = 0; j < OUT_SIZE; j++) begin : g_pair
        if (2 * j + 1 < VEC_SIZE) begin : g_add
            assign `VEC_ELEM(sum_o, j, FW) = float_add(`VEC_ELEM(vec_i, 2*j, FW),
                                                       `VEC_ELEM(vec_i, 2*j+1, FW));
        end else begin : g_pass
            assign `VEC_ELEM(sum_o, j, FW) = `VEC_ELEM(vec_i, 2*j, FW);
        end
    end

endmodule

// File: rtl/vec_sum_pipe.sv
// Pipelined, back-pressurable float vector sum: one register stage per pairwise level.
// Bubbles collapse because each stage is ready whenever it is empty or its successor is ready.
module vec_sum_pipe
    import vec_sum_pipe_pkg::*;
#(
    parameter int VEC_SIZE       = 8,
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int BIAS           = 127
) (
    input  logic                                                       clk,
    input  logic                                                       reset,
    input  logic                                                       in_valid,
    output logic                                                       in_ready,
    input  logic [VEC_SIZE*float_width(EXP_WIDTH, MANTISSA_WIDTH)-1:0] in_data,
    output logic                                                       out_valid,
    input  logic                                                       out_ready,
    output logic [float_width(EXP_WIDTH, MANTISSA_WIDTH)-1:0]          out_data,
    output logic                                                       busy
);
    localparam int FW     = float_width(EXP_WIDTH, MANTISSA_WIDTH);
    localparam int LEVELS = num_levels(VEC_SIZE);
    localparam int S      = (LEVELS > 0) ? LEVELS : 1;

    logic [S-1:0] vld_q, vld_d;
    logic [S-1:0] src_vld;
    logic [S:0]   rdy;

    assign rdy[S]    = out_ready;
    assign in_ready  = rdy[0];
    assign out_valid = vld_q[S-1];
    assign busy      = |vld_q;

    for (genvar k = 0; k < S; k++) begin : g_stg
        localparam int SZ = stage_size(VEC_SIZE, k);
        logic [SZ*FW-1:0] data_q, data_d;
        logic             xfer;

        assign rdy[k]   = ~vld_q[k] | rdy[k+1];
        assign xfer     = src_vld[k] & rdy[k];
        assign vld_d[k] = xfer | (vld_q[k] & ~rdy[k+1]);

        if (k == 0) begin : g_src
            assign src_vld[k] = in_valid;
            if (VEC_SIZE == 1) begin : g_bypass
                assign data_d = in_data;
            end else begin : g_red
                vec_sum_reduce #(
                    .VEC_SIZE(VEC_SIZE), .EXP_WIDTH(EXP_WIDTH),
                    .MANTISSA_WIDTH(MANTISSA_WIDTH), .BIAS(BIAS)
                ) u_red (
                    .vec_i(in_data),
                    .sum_o(data_d)
                );
            end
        end else begin : g_src
            assign src_vld[k] = vld_q[k-1];
            vec_sum_reduce #(
                .VEC_SIZE(stage_size(VEC_SIZE, k - 1)), .EXP_WIDTH(EXP_WIDTH),
                .MANTISSA_WIDTH(MANTISSA_WIDTH), .BIAS(BIAS)
            ) u_red (
                .vec_i(g_stg[k-1].data_q),
                .sum_o(data_d)
            );
        end

        always_ff @(posedge clk) begin
            if (reset) data_q <= '0;
            else if (xfer) data_q <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) vld_q <= '0;
        else vld_q <= vld_d;
    end

    assign out_data = g_stg[S-1].data_q;

endmodule

// File: tb/tb_vec_sum_pipe.sv
// Directed bench for vec_sum_pipe with VEC_SIZE 8, 5 and 1 instances sharing clock and reset.
module tb_vec_sum_pipe;

    logic clk;
    logic rst;

    logic         in8_valid, in8_ready, out8_valid, out8_ready, busy8;
    logic [255:0] in8_data;
    logic [31:0]  out8_data;

    logic         in5_valid, in5_ready, out5_valid, out5_ready, busy5;
    logic [159:0] in5_data;
    logic [31:0]  out5_data;

    logic         in1_valid, in1_ready, out1_valid, out1_ready, busy1;
    logic [31:0]  in1_data;
    logic [31:0]  out1_data;

    int n_vec;
    int n_miss;

    logic [31:0] tbl  [7][8];
    logic [31:0] sums [7];

    vec_sum_pipe #(.VEC_SIZE(8)) u_dut8 (
        .clk(clk), .reset(rst), .in_valid(in8_valid), .in_ready(in8_ready),
        .in_data(in8_data), .out_valid(out8_valid), .out_ready(out8_ready),
        .out_data(out8_data), .busy(busy8)
    );

    vec_sum_pipe #(.VEC_SIZE(5)) u_dut5 (
        .clk(clk), .reset(rst), .in_valid(in5_valid), .in_ready(in5_ready),
        .in_data(in5_data), .out_valid(out5_valid), .out_ready(out5_ready),
        .out_data(out5_data), .busy(busy5)
    );

    vec_sum_pipe #(.VEC_SIZE(1)) u_dut1 (
        .clk(clk), .reset(rst), .in_valid(in1_valid), .in_ready(in1_ready),
        .in_data(in1_data), .out_valid(out1_valid), .out_ready(out1_ready),
        .out_data(out1_data), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] pack8(input int k);
        logic [255:0] p;
        for (int i = 0; i < 8; i++) p[i*32 +: 32] = tbl[k][i];
        return p;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  idx, sent, rcv, cyc;
        logic take, have_hold, stale;
        logic [31:0] hold;

        n_vec  = 0;
        n_miss = 0;
        tbl[0] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                   32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        tbl[1] = '{default: 32'h3F800000};
        tbl[2] = '{default: 32'h40000000};
        tbl[3] = '{default: 32'h3F000000};
        tbl[4] = '{default: 32'h40800000};
        tbl[5] = '{32'h41000000, 32'hBF800000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[6] = '{32'h3F800000, 32'hBF800000, 32'h40000000, 32'hC0000000,
                   32'h40400000, 32'hC0400000, 32'h40800000, 32'hC0800000};
        sums   = '{32'h42100000, 32'h41000000, 32'h41800000, 32'h40800000,
                   32'h42000000, 32'h40E00000, 32'h00000000};

        rst = 1'b1;
        in8_valid = 1'b0; out8_ready = 1'b0; in8_data = '0;
        in5_valid = 1'b0; out5_ready = 1'b0; in5_data = '0;
        in1_valid = 1'b0; out1_ready = 1'b0; in1_data = '0;
        repeat (2) tick();
        chk("rst_out_valid", out8_valid, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_in_ready", in8_ready, 1);
        chk("rst_out_data", out8_data, 0);
        rst = 1'b0;
        tick();

        // 1..8 with free-running output: 36.0 three cycles after accept
        in8_valid = 1'b1; in8_data = pack8(0); out8_ready = 1'b1;
        #1;
        chk("t1_in_ready", in8_ready, 1);
        tick();
        in8_valid = 1'b0;
        chk("t1_lat1_valid", out8_valid, 0);
        tick();
        chk("t1_lat2_valid", out8_valid, 0);
        tick();
        chk("t1_lat3_valid", out8_valid, 1);
        chk("t1_sum", out8_data, 32'h42100000);
        tick();
        chk("t1_busy_fall", busy8, 0);
        chk("t1_valid_fall", out8_valid, 0);

        // odd-sized vector: tail element passes through every level
        in5_valid = 1'b1; out5_ready = 1'b1;
        in5_data = {32'h40A00000, 32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        tick();
        in5_valid = 1'b0;
        tick();
        chk("t2_lat2_valid", out5_valid, 0);
        tick();
        chk("t2_valid", out5_valid, 1);
        chk("t2_sum", out5_data, 32'h41700000);
        tick();
        chk("t2_busy_fall", busy5, 0);

        // capacity with stalled output
        out8_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            in8_valid = 1'b1;
            in8_data  = pack8(idx);
            #1;
            take = in8_ready;
            tick();
            if (take) idx++;
        end
        in8_valid = 1'b0;
        chk("t3_accepted", idx, 3);
        chk("t3_in_ready_low", in8_ready, 0);
        chk("t3_stall_valid", out8_valid, 1);
        chk("t3_stall_data", out8_data, sums[0]);
        tick();
        chk("t3_stall_hold", out8_data, sums[0]);
        out8_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("t3_drain_valid", out8_valid, 1);
            chk("t3_drain_sum", out8_data, sums[k]);
            tick();
        end
        chk("t3_drained", out8_valid, 0);
        chk("t3_busy_fall", busy8, 0);

        // back-to-back stream with toggling out_ready
        sent = 0; rcv = 0; cyc = 0; have_hold = 1'b0; hold = '0;
        while (rcv < 7 && cyc < 200) begin
            out8_ready = (cyc % 2 == 0);
            in8_valid  = (sent < 7);
            in8_data   = pack8((sent < 7) ? sent : 0);
            #1;
            if (have_hold) begin
                chk("t4_stall_stable", out8_data, hold);
                have_hold = 1'b0;
            end
            if (out8_valid && out8_ready) begin
                if (rcv < sent) chk("t4_sum", out8_data, sums[rcv]);
                else chk("t4_extra_output", rcv, sent - 1);
                rcv++;
            end else if (out8_valid) begin
                hold = out8_data;
                have_hold = 1'b1;
            end
            if (in8_valid && in8_ready) sent++;
            tick();
            cyc++;
        end
        in8_valid = 1'b0;
        chk("t4_received", rcv, 7);
        chk("t4_sent", sent, 7);
        out8_ready = 1'b1;
        tick();
        chk("t4_no_duplicate", out8_valid, 0);

        // reset with two vectors in flight
        in8_valid = 1'b1; in8_data = pack8(1);
        tick();
        in8_data = pack8(2);
        tick();
        in8_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_out_valid", out8_valid, 0);
        chk("t5_busy", busy8, 0);
        chk("t5_in_ready", in8_ready, 1);
        chk("t5_out_data", out8_data, 0);
        stale = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            stale = stale | out8_valid;
        end
        chk("t5_no_stale", stale, 0);

        // single-element vector: bypass with one-cycle latency
        in1_valid = 1'b1; in1_data = 32'h40490FDB; out1_ready = 1'b1;
        #1;
        chk("t6_in_ready", in1_ready, 1);
        tick();
        in1_valid = 1'b0;
        chk("t6_valid", out1_valid, 1);
        chk("t6_data", out1_data, 32'h40490FDB);
        tick();
        chk("t6_valid_fall", out1_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
